sitcpxg_rx_stream: RTL and testbench
====================================

Name: sitcpxg_rx_stream

Overview:
- Consumes the SiTCP XG TCP receive-buffer write interface (USER_RX_WADR/WENB/WDAT, big-endian byte enables, LongLong 64-bit layout).
- Stores the writes in an on-chip ring buffer and returns freed space to SiTCP through USER_RX_RADR.
- Presents received TCP bytes to user logic as a valid/ready stream of up to 8 bytes per beat.
- Sits directly downstream of the SiTCP XG wrapper, in the XGMII_CLOCK domain.

Parameters:
- BUF_AW, 16: byte-address width of the ring buffer (2^BUF_AW bytes; 64-bit RAM depth 2^(BUF_AW-3)); legal range 13..16.
- RX_SIZE, 16'd65520: value driven on USER_RX_SIZE; must be ≥4000 and ≤ 2^BUF_AW-16.

Ports:
- XGMII_CLOCK in 1: 156.25 MHz clock; all logic is on its rising edge.
- RSTn in 1: synchronous, active-low reset.
- USER_RX_SIZE out 16: constant RX_SIZE.
- USER_RX_CLR_ENB in 1: SiTCP allows a buffer clear.
- USER_RX_CLR_REQ out 1: buffer clear request to SiTCP.
- USER_RX_RADR out 16: byte read pointer; bits above BUF_AW are 0.
- USER_RX_WADR in 16: byte write address of the current word; bits [2:0] and bits ≥ BUF_AW are ignored.
- USER_RX_WENB in 8: byte enables; bit7 is the lowest-address byte, WDAT[63:56].
- USER_RX_WDAT in 64: write data, big endian.
- FLUSH_REQ in 1: user level request to discard buffered data.
- FLUSH_DONE out 1: one-cycle pulse when the flush completes.
- M_VALID out 1: stream beat valid.
- M_READY in 1: stream beat accepted.
- M_DATA out 64: left-aligned data; first byte in [63:56].
- M_BYTES out 4: byte count of the beat, 1..8.
- RX_LEVEL out 16: number of bytes held (wr_ptr − rd_ptr).
- OVERFLOW out 1: sticky flag, set when the buffer would exceed RX_SIZE.

Behaviour:
- Reset values (RSTn=0 at a clock edge): USER_RX_CLR_REQ, USER_RX_RADR, FLUSH_DONE, M_VALID, M_DATA, M_BYTES, RX_LEVEL, OVERFLOW are all 0. Internal wr_ptr, rd_ptr and the fetch pipeline are cleared. RAM contents are not reset.
- Write, WENB≠0:
  - Enabled bytes are written into word WADR[BUF_AW-1:3].
  - Enables are contiguous, starting at the lowest enabled byte offset.
  - wr_ptr ← {WADR[BUF_AW-1:3],3'b0} + (index of last enabled byte) + 1, modulo 2^BUF_AW.
  - wr_ptr updates one cycle after the RAM write commits, so no read-during-write hazard exists.
- Pointer arithmetic: BUF_AW-bit unsigned, wrapping at 2^BUF_AW. avail = wr_ptr − rd_ptr, modulo 2^BUF_AW.
- OVERFLOW: set if the new avail would be > RX_SIZE. Cleared only by reset.
- Fetch:
  - When avail_unissued > 0 and the output queue has a free slot, issue a RAM read of word rd_issue[BUF_AW-1:3].
  - Beat length n = min(8 − rd_issue[2:0], avail_unissued); data is shifted left by rd_issue[2:0] bytes and unused low bytes are 0.
  - Advance rd_issue by n.
  - A beat never crosses a word boundary, so wrap-around needs no special case.
- Latency and throughput:
  - RAM read latency is 1 cycle; the beat is registered into a 2-entry output queue.
  - First M_VALID appears 3 cycles after the write cycle.
  - Sustained throughput is 1 beat per cycle while M_READY=1.
- Handshake:
  - M_DATA and M_BYTES are stable while M_VALID=1 and M_READY=0.
  - A beat transfers on M_VALID&M_READY; at that point rd_ptr += M_BYTES and USER_RX_RADR updates the following cycle.
  - RADR therefore advances only on consumption.
- Full: when avail reaches RX_SIZE, SiTCP closes its TCP window. The block takes no action beyond OVERFLOW.
- Flush state machine, IDLE → WAIT_ENB → CLEAR → IDLE:
  - IDLE→WAIT_ENB on FLUSH_REQ=1.
  - In WAIT_ENB, M_VALID is forced to 0 and new fetches stop.
  - WAIT_ENB→CLEAR when USER_RX_CLR_ENB=1; USER_RX_CLR_REQ=1 for exactly that one cycle.
  - In CLEAR, wr_ptr, rd_ptr and rd_issue are set to 0, the output queue is emptied, and FLUSH_DONE pulses for 1 cycle.
  - A write arriving in the CLEAR cycle is discarded.
  - FLUSH_REQ held high does not retrigger until it has been seen low.
- Simultaneous write and consume: both pointers update in the same cycle and RX_LEVEL reflects both.
- Reset mid-beat: the beat is dropped and the stream restarts empty.

Decomposition:
- Package sitcpxg_rx_pkg holds:
  - RX_DW=64, RX_BW=8;
  - the flush-state enum (IDLE, WAIT_ENB, CLEAR);
  - a function last_byte_idx(wenb) returning 0..7;
  - a function beat_len(offset, avail).
- Sub-module sitcpxg_rx_ram: simple dual-port RAM, 64-bit with 8 byte-write enables, 1-cycle registered read, depth 2^(BUF_AW-3).

Test Plan:
- Single write, WADR=0x0000, WENB=0xFF, WDAT=0x0011223344556677, M_READY=1 → M_VALID at cycle +3 with M_DATA=0x0011223344556677, M_BYTES=8; then RADR=0x0008 and RX_LEVEL=0.
- Partial word:
  - Write WADR=0x0000, WENB=0xE0, data AABBCC.. → beat M_BYTES=3, M_DATA=0xAABBCC0000000000.
  - Then WENB=0x1F, data ..DDEEFF0011 → beat M_BYTES=5, M_DATA=0xDDEEFF0011000000; RADR=0x0008.
- Back-pressure: write 4 full words with M_READY=0 → M_VALID=1 with the first word held stable and RADR=0. Raise M_READY → 4 beats on consecutive cycles; RADR=0x0020.
- Wrap: BUF_AW=13, start pointers at 0x1FF8, write WADR=0x1FF8 and WADR=0x0000 full → beats in order; RADR goes 0x0000 then 0x0008, with no gap.
- Flush: 24 bytes buffered, FLUSH_REQ=1, USER_RX_CLR_ENB=0 for 5 cycles then 1 → M_VALID=0 while waiting; USER_RX_CLR_REQ is a 1-cycle pulse when ENB rises; FLUSH_DONE pulses; RX_LEVEL=0 and RADR=0.
- Overflow: RX_SIZE=4096, write 4104 bytes with M_READY=0 → OVERFLOW=1 and stays 1 after draining; RSTn=0 → OVERFLOW=0.

Source files
------------

// File: rtl/sitcpxg_rx_pkg.sv
// Shared constants, flush FSM states and byte-lane helpers for the SiTCP XG receive stream.
package sitcpxg_rx_pkg;

    localparam int unsigned RX_DW = 64;
    localparam int unsigned RX_BW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWaitEnb,
        StClear
    } flush_state_e;

    // Enables are contiguous; the lowest set bit marks the highest byte address in the word.
    function automatic logic [2:0] last_byte_idx(input logic [7:0] wenb);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (wenb[i]) idx = 3'(7 - i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] beat_len(input logic [2:0] offset, input logic [15:0] avail);
        logic [3:0] room;
        room = 4'd8 - {1'b0, offset};
        return (avail < 16'(room)) ? avail[3:0] : room;
    endfunction

endpackage

// File: rtl/sitcpxg_rx_ram.sv
// Simple dual-port 64-bit RAM with per-byte write enables and a registered read port.
module sitcpxg_rx_ram
    import sitcpxg_rx_pkg::*;
#(
    parameter int unsigned AddrW = 13
) (
    input  logic             clk_i,
    input  logic [RX_BW-1:0] we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [RX_DW-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [RX_DW-1:0] rdata_o
);

    logic [RX_DW-1:0] mem [2**AddrW];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < int'(RX_BW); b++) begin
            if (we_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/sitcpxg_rx_stream.sv
// SiTCP XG receive-buffer sink: ring buffer fed by USER_RX_W*, drained as a byte-counted
// valid/ready stream, with RADR returned to SiTCP only as beats are consumed.
module sitcpxg_rx_stream
    import sitcpxg_rx_pkg::*;
#(
    parameter int unsigned BUF_AW  = 16,
    parameter logic [15:0] RX_SIZE = 16'd65520
) (
    input  logic             XGMII_CLOCK,
    input  logic             RSTn,
    output logic [15:0]      USER_RX_SIZE,
    input  logic             USER_RX_CLR_ENB,
    output logic             USER_RX_CLR_REQ,
    output logic [15:0]      USER_RX_RADR,
    input  logic [15:0]      USER_RX_WADR,
    input  logic [RX_BW-1:0] USER_RX_WENB,
    input  logic [RX_DW-1:0] USER_RX_WDAT,
    input  logic             FLUSH_REQ,
    output logic             FLUSH_DONE,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [RX_DW-1:0] M_DATA,
    output logic [3:0]       M_BYTES,
    output logic [15:0]      RX_LEVEL,
    output logic             OVERFLOW
);

    localparam int unsigned WAW = BUF_AW - 3;

    typedef logic [BUF_AW-1:0] ptr_t;

    flush_state_e state_q;
    logic         flush_armed_q;
    logic         clr_req_q;
    logic         flush_done_q;

    ptr_t wr_ptr_q, rd_ptr_q, rd_issue_q, wr_new_q;
    logic wr_pend_q;
    logic ovf_q;

    logic       s1_valid_q;
    logic [2:0] s1_off_q;
    logic [3:0] s1_len_q;

    logic [1:0]       q_cnt_q;
    logic [RX_DW-1:0] h_data_q, t_data_q;
    logic [3:0]       h_bytes_q, t_bytes_q;

    logic             in_idle;
    logic             wr_en;
    ptr_t             wr_end;
    ptr_t             avail_unissued;
    ptr_t             rd_ptr_d;
    ptr_t             new_avail;
    ptr_t             level;
    logic             pop;
    logic [1:0]       occ;
    logic             issue;
    logic [3:0]       issue_len;
    logic [3:0]       s1_pad;
    logic [RX_DW-1:0] ram_rdata;
    logic [RX_DW-1:0] beat_data;
    logic             unused_wadr;

    assign in_idle        = (state_q == StIdle);
    assign wr_en          = (|USER_RX_WENB) && (state_q != StClear);
    assign wr_end         = {USER_RX_WADR[BUF_AW-1:3], 3'b000}
                            + ptr_t'(last_byte_idx(USER_RX_WENB)) + ptr_t'(1);
    assign avail_unissued = wr_ptr_q - rd_issue_q;
    assign pop            = M_VALID && M_READY;
    assign rd_ptr_d       = pop ? rd_ptr_q + ptr_t'(h_bytes_q) : rd_ptr_q;
    assign new_avail      = wr_new_q - rd_ptr_d;
    assign level          = wr_ptr_q - rd_ptr_q;

    // Count the beat still in the RAM read stage so the 2-entry queue can never overrun.
    assign occ       = q_cnt_q + 2'(s1_valid_q);
    assign issue     = in_idle && (avail_unissued != '0) && ((occ - 2'(pop)) < 2'd2);
    assign issue_len = beat_len(rd_issue_q[2:0], 16'(avail_unissued));

    assign s1_pad    = 4'd8 - s1_len_q;
    assign beat_data = (ram_rdata << {s1_off_q, 3'b000}) & ({RX_DW{1'b1}} << {s1_pad, 3'b000});

    assign unused_wadr = ^USER_RX_WADR;

    sitcpxg_rx_ram #(
        .AddrW(WAW)
    ) u_ram (
        .clk_i  (XGMII_CLOCK),
        .we_i   (wr_en ? USER_RX_WENB : '0),
        .waddr_i(USER_RX_WADR[BUF_AW-1:3]),
        .wdata_i(USER_RX_WDAT),
        .re_i   (issue),
        .raddr_i(rd_issue_q[BUF_AW-1:3]),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge XGMII_CLOCK) begin
        if (!RSTn) begin
            state_q       <= StIdle;
            flush_armed_q <= 1'b1;
            clr_req_q     <= 1'b0;
            flush_done_q  <= 1'b0;
        end else begin
            clr_req_q    <= 1'b0;
            flush_done_q <= 1'b0;
            if (!FLUSH_REQ) flush_armed_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (FLUSH_REQ && flush_armed_q) begin
                        state_q       <= StWaitEnb;
                        flush_armed_q <= 1'b0;
                    end
                end
                StWaitEnb: begin
                    if (USER_RX_CLR_ENB) begin
                        state_q   <= StClear;
                        clr_req_q <= 1'b1;
                    end
                end
                StClear: begin
                    state_q      <= StIdle;
                    flush_done_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge XGMII_CLOCK) begin
        if (!RSTn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_issue_q <= '0;
            wr_new_q   <= '0;
            wr_pend_q  <= 1'b0;
            ovf_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_off_q   <= '0;
            s1_len_q   <= '0;
            q_cnt_q    <= '0;
            h_data_q   <= '0;
            t_data_q   <= '0;
            h_bytes_q  <= '0;
            t_bytes_q  <= '0;
        end else if (state_q == StClear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_issue_q <= '0;
            wr_pend_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            q_cnt_q    <= '0;
        end else begin
            // Pointer lags the RAM write by one cycle, so a fetch never reads a word mid-write.
            wr_pend_q <= wr_en;
            if (wr_en) wr_new_q <= wr_end;
            if (wr_pend_q) begin
                wr_ptr_q <= wr_new_q;
                if (32'(new_avail) > 32'(RX_SIZE)) ovf_q <= 1'b1;
            end

            rd_ptr_q <= rd_ptr_d;

            s1_valid_q <= issue;
            if (issue) begin
                s1_off_q   <= rd_issue_q[2:0];
                s1_len_q   <= issue_len;
                rd_issue_q <= rd_issue_q + ptr_t'(issue_len);
            end

            case ({s1_valid_q, pop})
                2'b10: begin
                    if (q_cnt_q == 2'd0) begin
                        h_data_q  <= beat_data;
                        h_bytes_q <= s1_len_q;
                    end else begin
                        t_data_q  <= beat_data;
                        t_bytes_q <= s1_len_q;
                    end
                    q_cnt_q <= q_cnt_q + 2'd1;
                end
                2'b01: begin
                    h_data_q  <= t_data_q;
                    h_bytes_q <= t_bytes_q;
                    q_cnt_q   <= q_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (q_cnt_q == 2'd1) begin
                        h_data_q  <= beat_data;
                        h_bytes_q <= s1_len_q;
                    end else begin
                        h_data_q  <= t_data_q;
                        h_bytes_q <= t_bytes_q;
                        t_data_q  <= beat_data;
                        t_bytes_q <= s1_len_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign USER_RX_SIZE    = RX_SIZE;
    assign USER_RX_CLR_REQ = clr_req_q;
    assign USER_RX_RADR    = 16'(rd_ptr_q);
    assign FLUSH_DONE      = flush_done_q;
    assign M_VALID         = (q_cnt_q != 2'd0) && in_idle;
    assign M_DATA          = h_data_q;
    assign M_BYTES         = h_bytes_q;
    assign RX_LEVEL        = 16'(level);
    assign OVERFLOW        = ovf_q;

endmodule

// File: tb/tb_sitcpxg_rx_stream.sv
// Bench for sitcpxg_rx_stream: directed scenarios plus randomized SiTCP-style writes,
// checked against a byte-queue reference of the TCP stream.
module tb_sitcpxg_rx_stream;

    localparam int unsigned AW   = 13;
    localparam int unsigned RING = 1 << AW;
    localparam int unsigned SIZE = 4096;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic [15:0] USER_RX_SIZE;
    logic        USER_RX_CLR_ENB = 1'b0;
    logic        USER_RX_CLR_REQ;
    logic [15:0] USER_RX_RADR;
    logic [15:0] USER_RX_WADR = '0;
    logic [7:0]  USER_RX_WENB = '0;
    logic [63:0] USER_RX_WDAT = '0;
    logic        FLUSH_REQ = 1'b0;
    logic        FLUSH_DONE;
    logic        M_VALID;
    logic        M_READY = 1'b0;
    logic [63:0] M_DATA;
    logic [3:0]  M_BYTES;
    logic [15:0] RX_LEVEL;
    logic        OVERFLOW;

    always #5 clk = ~clk;

    sitcpxg_rx_stream #(
        .BUF_AW (AW),
        .RX_SIZE(16'(SIZE))
    ) dut (
        .XGMII_CLOCK    (clk),
        .RSTn           (RSTn),
        .USER_RX_SIZE   (USER_RX_SIZE),
        .USER_RX_CLR_ENB(USER_RX_CLR_ENB),
        .USER_RX_CLR_REQ(USER_RX_CLR_REQ),
        .USER_RX_RADR   (USER_RX_RADR),
        .USER_RX_WADR   (USER_RX_WADR),
        .USER_RX_WENB   (USER_RX_WENB),
        .USER_RX_WDAT   (USER_RX_WDAT),
        .FLUSH_REQ      (FLUSH_REQ),
        .FLUSH_DONE     (FLUSH_DONE),
        .M_VALID        (M_VALID),
        .M_READY        (M_READY),
        .M_DATA         (M_DATA),
        .M_BYTES        (M_BYTES),
        .RX_LEVEL       (RX_LEVEL),
        .OVERFLOW       (OVERFLOW)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference: bytes written by SiTCP but not yet consumed, in stream order.
    byte unsigned exp_q[$];
    int unsigned  wp = 0;
    int unsigned  model_rd = 0;
    int unsigned  sent_total = 0;
    int unsigned  took_total = 0;
    int unsigned  beat_cnt = 0;
    logic [63:0]  last_data = '0;
    int unsigned  last_bytes = 0;
    bit           mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int unsigned addr, input logic [7:0] wenb,
                              input logic [63:0] data);
        int lo;
        lo = 0;
        USER_RX_WADR = 16'(addr);
        USER_RX_WENB = wenb;
        USER_RX_WDAT = data;
        for (int b = 7; b >= 0; b--) begin
            if (wenb[b]) begin
                exp_q.push_back(data[8*b +: 8]);
                sent_total++;
                lo = b;
            end
        end
        wp = ((addr & ~32'd7) + 8 - lo) % RING;
        tick();
        USER_RX_WENB = '0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        RSTn = 1'b0;
        USER_RX_WENB = '0;
        FLUSH_REQ = 1'b0;
        USER_RX_CLR_ENB = 1'b0;
        tick();
        tick();
        exp_q.delete();
        wp = 0;
        model_rd = 0;
        sent_total = 0;
        took_total = 0;
        beat_cnt = 0;
        RSTn = 1'b1;
        mon_en = 1'b1;
    endtask

    // Stream monitor: checks every accepted beat against the reference and the hold rule.
    initial begin
        bit          stall_prev;
        logic [63:0] stall_data;
        logic [3:0]  stall_bytes;
        int unsigned n;
        logic [63:0] exp;
        stall_prev = 1'b0;
        stall_data = '0;
        stall_bytes = '0;
        forever begin
            @(negedge clk);
            if (RSTn && mon_en) begin
                check("radr", USER_RX_RADR, model_rd);
                if (stall_prev) begin
                    check("hold_valid", M_VALID, 1);
                    check("hold_data", M_DATA, stall_data);
                    check("hold_bytes", M_BYTES, stall_bytes);
                end
                if (M_VALID && M_READY) begin
                    n = M_BYTES;
                    check("bytes_range", (n >= 1 && n <= 8), 1);
                    check("no_cross", (n <= 8 - model_rd % 8), 1);
                    check("have_data", (n <= exp_q.size()), 1);
                    if (n >= 1 && n <= 8 && n <= exp_q.size()) begin
                        exp = '0;
                        for (int i = 0; i < int'(n); i++) exp[63-8*i -: 8] = exp_q.pop_front();
                        check("beat_data", M_DATA, exp);
                    end
                    model_rd = (model_rd + n) % RING;
                    took_total += n;
                    last_data = M_DATA;
                    last_bytes = n;
                    beat_cnt++;
                end
                stall_prev = M_VALID && !M_READY;
                stall_data = M_DATA;
                stall_bytes = M_BYTES;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        logic [63:0] d0;
        logic [7:0]  ff;
        logic [7:0]  wenb;
        int unsigned off, k;
        int          nc;
        int          chg_val [4];
        int          chg_at  [4];
        logic [15:0] prev;

        ff = 8'hFF;
        do_reset();

        // Reset state
        check("rst_clr_req", USER_RX_CLR_REQ, 0);
        check("rst_radr", USER_RX_RADR, 0);
        check("rst_flush_done", FLUSH_DONE, 0);
        check("rst_mvalid", M_VALID, 0);
        check("rst_mdata", M_DATA, 0);
        check("rst_mbytes", M_BYTES, 0);
        check("rst_level", RX_LEVEL, 0);
        check("rst_overflow", OVERFLOW, 0);
        check("rx_size", USER_RX_SIZE, SIZE);

        // Single full word: first M_VALID three cycles after the write cycle
        M_READY = 1'b1;
        write_word(0, 8'hFF, 64'h0011223344556677);
        tick();
        tick();
        check("lat_early", M_VALID, 0);
        tick();
        check("lat_valid", M_VALID, 1);
        check("lat_data", M_DATA, 64'h0011223344556677);
        check("lat_bytes", M_BYTES, 8);
        tick();
        tick();
        check("single_radr", USER_RX_RADR, 16'h0008);
        check("single_level", RX_LEVEL, 0);

        // Partial words
        do_reset();
        M_READY = 1'b1;
        write_word(0, 8'hE0, 64'hAABBCC1122334455);
        repeat (6) tick();
        check("part1_bytes", last_bytes, 3);
        check("part1_data", last_data, 64'hAABBCC0000000000);
        write_word(0, 8'h1F, 64'h112233DDEEFF0011);
        repeat (6) tick();
        check("part2_bytes", last_bytes, 5);
        check("part2_data", last_data, 64'hDDEEFF0011000000);
        check("part_beats", beat_cnt, 2);
        check("part_radr", USER_RX_RADR, 16'h0008);

        // Back-pressure then a burst of consecutive beats
        do_reset();
        M_READY = 1'b0;
        d0 = {$urandom, $urandom};
        write_word(0, 8'hFF, d0);
        for (int w = 1; w < 4; w++) write_word(w * 8, 8'hFF, {$urandom, $urandom});
        repeat (8) tick();
        check("bp_valid", M_VALID, 1);
        check("bp_data", M_DATA, d0);
        check("bp_radr", USER_RX_RADR, 0);
        check("bp_level", RX_LEVEL, 32);
        M_READY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("bp_burst", beat_cnt, i);
        end
        tick();
        check("bp_radr_end", USER_RX_RADR, 16'h0020);
        check("bp_level_end", RX_LEVEL, 0);

        // Wrap at the top of the ring
        do_reset();
        M_READY = 1'b1;
        for (int w = 0; w < 1023; w++) write_word(w * 8, 8'hFF, {$urandom, $urandom});
        repeat (10) tick();
        check("wrap_pre_radr", USER_RX_RADR, 16'h1FF8);
        write_word(16'h1FF8, 8'hFF, {$urandom, $urandom});
        write_word(0, 8'hFF, {$urandom, $urandom});
        nc = 0;
        prev = USER_RX_RADR;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (USER_RX_RADR != prev && nc < 4) begin
                chg_val[nc] = int'(USER_RX_RADR);
                chg_at[nc] = t;
                nc++;
                prev = USER_RX_RADR;
            end
        end
        check("wrap_changes", nc, 2);
        if (nc >= 2) begin
            check("wrap_radr0", chg_val[0], 0);
            check("wrap_radr1", chg_val[1], 8);
            check("wrap_no_gap", chg_at[1] - chg_at[0], 1);
        end

        // Flush handshake
        do_reset();
        M_READY = 1'b0;
        for (int w = 0; w < 3; w++) write_word(w * 8, 8'hFF, {$urandom, $urandom});
        repeat (6) tick();
        check("fl_level", RX_LEVEL, 24);
        mon_en = 1'b0;
        FLUSH_REQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fl_wait_mvalid", M_VALID, 0);
            check("fl_wait_clrreq", USER_RX_CLR_REQ, 0);
        end
        USER_RX_CLR_ENB = 1'b1;
        tick();
        check("fl_clrreq_hi", USER_RX_CLR_REQ, 1);
        check("fl_done_early", FLUSH_DONE, 0);
        tick();
        check("fl_clrreq_lo", USER_RX_CLR_REQ, 0);
        check("fl_done_hi", FLUSH_DONE, 1);
        check("fl_level0", RX_LEVEL, 0);
        check("fl_radr0", USER_RX_RADR, 0);
        tick();
        check("fl_done_lo", FLUSH_DONE, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fl_no_retrig", USER_RX_CLR_REQ, 0);
        end
        FLUSH_REQ = 1'b0;
        USER_RX_CLR_ENB = 1'b0;
        exp_q.delete();
        wp = 0;
        model_rd = 0;
        beat_cnt = 0;
        mon_en = 1'b1;
        M_READY = 1'b1;
        write_word(0, 8'hFF, {$urandom, $urandom});
        repeat (6) tick();
        check("fl_restart_beats", beat_cnt, 1);

        // Overflow is sticky until reset
        do_reset();
        M_READY = 1'b0;
        for (int w = 0; w < 512; w++) write_word(w * 8, 8'hFF, {$urandom, $urandom});
        repeat (4) tick();
        check("ovf_at_size", OVERFLOW, 0);
        check("ovf_level_size", RX_LEVEL, 4096);
        write_word(4096, 8'hFF, {$urandom, $urandom});
        repeat (3) tick();
        check("ovf_set", OVERFLOW, 1);
        check("ovf_level", RX_LEVEL, 4104);
        M_READY = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (RX_LEVEL == 0 && !M_VALID) break;
            tick();
        end
        check("ovf_drained", RX_LEVEL, 0);
        check("ovf_sticky", OVERFLOW, 1);
        do_reset();
        check("ovf_reset", OVERFLOW, 0);

        // Randomized SiTCP writes with random back-pressure and a reset mid-stream
        do_reset();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            M_READY = ($urandom % 4) != 0;
            if (cyc == 3000) begin
                do_reset();
                check("rnd_rst_mvalid", M_VALID, 0);
                check("rnd_rst_level", RX_LEVEL, 0);
            end else if (($urandom % 3) != 0) begin
                off = wp % 8;
                k = $urandom_range(1, 8 - off);
                if (sent_total - took_total + k <= SIZE - 64) begin
                    wenb = (ff >> off) & ~(ff >> (off + k));
                    write_word(wp, wenb, {$urandom, $urandom});
                end else begin
                    tick();
                end
            end else begin
                tick();
            end
        end
        M_READY = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (RX_LEVEL == 0 && !M_VALID && exp_q.size() == 0) break;
            tick();
        end
        tick();
        check("rnd_level", RX_LEVEL, 0);
        check("rnd_mvalid", M_VALID, 0);
        check("rnd_radr", USER_RX_RADR, wp);
        check("rnd_all_taken", took_total, sent_total);
        check("rnd_model_empty", exp_q.size(), 0);
        check("rnd_no_ovf", OVERFLOW, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
